// File: rtl/vecunit_pkg.sv
// Shared vecunit definitions: sizing helpers and producer identifiers.
package vecunit_pkg;

  localparam logic P0_ID = 1'b0;
  localparam logic P1_ID = 1'b1;

  // Ceiling log2; log2(1) = 0.
  function automatic int log2(input int n);
    int r;
    r = 0;
    for (int k = 0; k < 32; k++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

  // Bits needed to encode n distinct values, never less than one.
  function automatic int bitwidth(input int n);
    return (log2(n) < 1) ? 1 : log2(n);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Queue storage: per-entry registers cleared by reset, one write port, combinational read.
module fifo_mem
  import vecunit_pkg::*;
#(
  parameter int SIZE  = 4,
  parameter int WIDTH = 8,
  localparam int AW   = bitwidth(SIZE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             w_en,
  input  logic [AW-1:0]    w_addr,
  input  logic [WIDTH-1:0] w_data,
  input  logic [AW-1:0]    r_addr,
  output logic [WIDTH-1:0] r_data
);

  logic [WIDTH-1:0] mem_reg [SIZE];

  for (genvar gi = 0; gi < SIZE; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (rst) begin
        mem_reg[gi] <= '0;
      end else if (w_en && (w_addr == AW'(gi))) begin
        mem_reg[gi] <= w_data;
      end
    end
  end

  assign r_data = mem_reg[r_addr];

endmodule

// File: rtl/vq_fifo_arb_ctrl.sv
// Vecunit queue controller: two producers share the fifo_mem write port through a
// round-robin arbiter; one consumer drains the head.
module vq_fifo_arb_ctrl
  import vecunit_pkg::*;
#(
  parameter int SIZE      = 4,
  parameter int WIDTH     = 8,
  parameter int AF_THRESH = 3,
  localparam int PW       = bitwidth(SIZE),
  localparam int CW       = bitwidth(SIZE + 1)
) (
  input  logic             clk_i,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             p0_valid_i,
  input  logic [WIDTH-1:0] p0_data_i,
  output logic             p0_ready_o,
  input  logic             p1_valid_i,
  input  logic [WIDTH-1:0] p1_data_i,
  output logic             p1_ready_o,
  output logic             c_valid_o,
  output logic [WIDTH-1:0] c_data_o,
  input  logic             c_ready_i,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             almost_full_o
);

  if ((SIZE < 2) || (AF_THRESH < 1) || (AF_THRESH > SIZE)) begin : g_param_check
    $error("vq_fifo_arb_ctrl: illegal SIZE/AF_THRESH combination");
  end

  logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]    count_reg, count_next;
  logic             rr_last_reg, rr_last_next;
  logic             grant0, grant1;
  logic             push, pop;
  logic [WIDTH-1:0] push_data;

  // Flags come from the registered count only, so c_ready_i never reaches px_ready_o.
  assign full_o        = (count_reg == CW'(SIZE));
  assign empty_o       = (count_reg == '0);
  assign almost_full_o = (count_reg >= CW'(AF_THRESH));
  assign count_o       = count_reg;
  assign c_valid_o     = ~empty_o;

  // On a tie the producer that did not win the last accepted push is granted.
  assign grant0 = p0_valid_i & (~p1_valid_i | (rr_last_reg == P1_ID));
  assign grant1 = p1_valid_i & (~p0_valid_i | (rr_last_reg == P0_ID));

  assign p0_ready_o = grant0 & ~full_o & ~flush_i & ~rst;
  assign p1_ready_o = grant1 & ~full_o & ~flush_i & ~rst;

  assign push      = (p0_valid_i & p0_ready_o) | (p1_valid_i & p1_ready_o);
  assign pop       = c_valid_o & c_ready_i & ~flush_i;
  assign push_data = grant1 ? p1_data_i : p0_data_i;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == PW'(SIZE - 1)) ? '0 : ptr + PW'(1);
  endfunction

  always_comb begin
    wr_ptr_next  = wr_ptr_reg;
    rd_ptr_next  = rd_ptr_reg;
    count_next   = count_reg;
    rr_last_next = rr_last_reg;
    if (flush_i) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) begin
        wr_ptr_next  = ptr_inc(wr_ptr_reg);
        rr_last_next = grant1 ? P1_ID : P0_ID;
      end
      if (pop) begin
        rd_ptr_next = ptr_inc(rd_ptr_reg);
      end
      case ({push, pop})
        2'b10:   count_next = count_reg + CW'(1);
        2'b01:   count_next = count_reg - CW'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      rr_last_reg <= P1_ID;
    end else begin
      wr_ptr_reg  <= wr_ptr_next;
      rd_ptr_reg  <= rd_ptr_next;
      count_reg   <= count_next;
      rr_last_reg <= rr_last_next;
    end
  end

  fifo_mem #(
    .SIZE  (SIZE),
    .WIDTH (WIDTH)
  ) u_mem (
    .clk    (clk_i),
    .rst    (rst),
    .w_en   (push),
    .w_addr (wr_ptr_reg),
    .w_data (push_data),
    .r_addr (rd_ptr_reg),
    .r_data (c_data_o)
  );

endmodule

// File: tb/tb_vq_fifo_arb_ctrl.sv
// Directed self-checking bench for vq_fifo_arb_ctrl with SIZE=4, WIDTH=8, AF_THRESH=3.
module tb_vq_fifo_arb_ctrl;

  logic       clk_i = 1'b0;
  logic       rst = 1'b1;
  logic       flush_i = 1'b0;
  logic       p0_valid_i = 1'b0;
  logic [7:0] p0_data_i = 8'h00;
  logic       p0_ready_o;
  logic       p1_valid_i = 1'b0;
  logic [7:0] p1_data_i = 8'h00;
  logic       p1_ready_o;
  logic       c_valid_o;
  logic [7:0] c_data_o;
  logic       c_ready_i = 1'b0;
  logic [2:0] count_o;
  logic       full_o, empty_o, almost_full_o;

  int total = 0;
  int bad = 0;

  always #5 clk_i = ~clk_i;

  vq_fifo_arb_ctrl #(.SIZE(4), .WIDTH(8), .AF_THRESH(3)) dut (
    .clk_i         (clk_i),
    .rst           (rst),
    .flush_i       (flush_i),
    .p0_valid_i    (p0_valid_i),
    .p0_data_i     (p0_data_i),
    .p0_ready_o    (p0_ready_o),
    .p1_valid_i    (p1_valid_i),
    .p1_data_i     (p1_data_i),
    .p1_ready_o    (p1_ready_o),
    .c_valid_o     (c_valid_o),
    .c_data_o      (c_data_o),
    .c_ready_i     (c_ready_i),
    .count_o       (count_o),
    .full_o        (full_o),
    .empty_o       (empty_o),
    .almost_full_o (almost_full_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n0, n1;
    logic [7:0] exp_q [$];

    // Reset for two cycles with producers requesting.
    p0_valid_i = 1'b1;
    p1_valid_i = 1'b1;
    #1;
    check("rst_p0_ready", 32'(p0_ready_o), 0);
    check("rst_p1_ready", 32'(p1_ready_o), 0);
    step();
    step();
    check("rst_count", 32'(count_o), 0);
    check("rst_empty", 32'(empty_o), 1);
    check("rst_c_valid", 32'(c_valid_o), 0);
    check("rst_full", 32'(full_o), 0);
    check("rst_af", 32'(almost_full_o), 0);
    check("rst_p0_ready_late", 32'(p0_ready_o), 0);
    p0_valid_i = 1'b0;
    p1_valid_i = 1'b0;
    rst = 1'b0;
    #1;

    // Fill from P0 with the consumer stalled.
    for (int i = 0; i < 4; i++) begin
      p0_valid_i = 1'b1;
      p0_data_i  = 8'(8'h11 * (i + 1));
      #1;
      check($sformatf("fill_ready_%0d", i), 32'(p0_ready_o), 1);
      step();
      check($sformatf("fill_count_%0d", i), 32'(count_o), 32'(i + 1));
      check($sformatf("fill_af_%0d", i), 32'(almost_full_o), (i >= 2) ? 1 : 0);
      check($sformatf("fill_full_%0d", i), 32'(full_o), (i == 3) ? 1 : 0);
      check($sformatf("fill_head_%0d", i), 32'(c_data_o), 32'h11);
    end
    p0_data_i = 8'h55;
    #1;
    check("full_p0_ready", 32'(p0_ready_o), 0);
    p0_valid_i = 1'b0;

    // Drain in order.
    c_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("drain_data_%0d", i), 32'(c_data_o), 32'(8'h11 * (i + 1)));
      check($sformatf("drain_valid_%0d", i), 32'(c_valid_o), 1);
      step();
    end
    c_ready_i = 1'b0;
    check("drain_empty", 32'(empty_o), 1);
    check("drain_count", 32'(count_o), 0);

    // Short reset re-arms the arbiter so P0 wins the first tie.
    rst = 1'b1;
    step();
    rst = 1'b0;

    // Round-robin with both producers always valid.
    n0 = 0;
    n1 = 0;
    p0_valid_i = 1'b1;
    p1_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      p0_data_i = 8'(8'hA0 + n0);
      p1_data_i = 8'(8'hB0 + n1);
      #1;
      check($sformatf("rr_p0_ready_%0d", i), 32'(p0_ready_o), (i % 2 == 0) ? 1 : 0);
      check($sformatf("rr_p1_ready_%0d", i), 32'(p1_ready_o), (i % 2 == 1) ? 1 : 0);
      if (p0_ready_o) n0++;
      if (p1_ready_o) n1++;
      step();
    end
    p0_valid_i = 1'b0;
    p1_valid_i = 1'b0;
    check("rr_full", 32'(full_o), 1);
    exp_q = '{8'hA0, 8'hB0, 8'hA1, 8'hB1};
    c_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("rr_order_%0d", i), 32'(c_data_o), 32'(exp_q[i]));
      step();
    end
    c_ready_i = 1'b0;

    // Bring count to 2, then push and pop together for 10 cycles across pointer wraps.
    p0_valid_i = 1'b1;
    p0_data_i  = 8'h50;
    step();
    p0_data_i  = 8'h51;
    step();
    check("wrap_pre_count", 32'(count_o), 2);
    c_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      p0_data_i = 8'(8'h52 + i);
      #1;
      check($sformatf("wrap_pop_%0d", i), 32'(c_data_o), 32'(8'h50 + i));
      step();
      check($sformatf("wrap_count_%0d", i), 32'(count_o), 2);
    end
    c_ready_i = 1'b0;

    // Full plus pop: the pop happens, the push waits one cycle.
    p0_data_i = 8'h60;
    step();
    p0_data_i = 8'h61;
    step();
    check("fp_full", 32'(full_o), 1);
    p0_data_i = 8'h62;
    c_ready_i = 1'b1;
    #1;
    check("fp_p0_blocked", 32'(p0_ready_o), 0);
    check("fp_head", 32'(c_data_o), 32'h5A);
    step();
    c_ready_i = 1'b0;
    check("fp_count_after_pop", 32'(count_o), 3);
    #1;
    check("fp_p0_ready_next", 32'(p0_ready_o), 1);
    step();
    p0_valid_i = 1'b0;
    check("fp_count_after_push", 32'(count_o), 4);

    // Pop one to reach count 3, then flush alongside a push and a pop.
    c_ready_i = 1'b1;
    step();
    check("fl_pre_count", 32'(count_o), 3);
    check("fl_pre_head", 32'(c_data_o), 32'h60);
    flush_i    = 1'b1;
    p0_valid_i = 1'b1;
    p0_data_i  = 8'h77;
    #1;
    check("fl_p0_ready", 32'(p0_ready_o), 0);
    step();
    flush_i    = 1'b0;
    p0_valid_i = 1'b0;
    c_ready_i  = 1'b0;
    check("fl_count", 32'(count_o), 0);
    check("fl_empty", 32'(empty_o), 1);
    check("fl_c_valid", 32'(c_valid_o), 0);
    check("fl_af", 32'(almost_full_o), 0);

    // Queue works normally after flush; first push lands at entry 0.
    p0_valid_i = 1'b1;
    p0_data_i  = 8'h88;
    step();
    p0_valid_i = 1'b0;
    check("post_fl_count", 32'(count_o), 1);
    check("post_fl_data", 32'(c_data_o), 32'h88);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
